// File: rtl/rv_register_file_pkg.sv
// Shared constants and types for the RV32I integer register file (package rf_pkg).
package rf_pkg;
  localparam int          REG_COUNT        = 32;
  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam logic [4:0]  REG_SP           = 5'd2;
  localparam logic [31:0] SP_RESET_DEFAULT = 32'h0110_0000;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] reg_data_t;
endpackage

// File: rtl/rv_register_file_if.sv
// Register-file access bundle: two read ports and one writeback port.
interface rv_register_file_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic [AWIDTH-1:0] rs1_i;
  logic [AWIDTH-1:0] rs2_i;
  logic [AWIDTH-1:0] rd_i;
  logic [DWIDTH-1:0] datawb_i;
  logic              regwren_i;
  logic [DWIDTH-1:0] rs1data_o;
  logic [DWIDTH-1:0] rs2data_o;

  modport master (
    output rs1_i, rs2_i, rd_i, datawb_i, regwren_i,
    input  rs1data_o, rs2data_o
  );

  modport slave (
    input  rs1_i, rs2_i, rd_i, datawb_i, regwren_i,
    output rs1data_o, rs2data_o
  );
endinterface

// File: rtl/rv_register_file_read_port.sv
// One combinational read port: index select, x0 masking and optional writeback bypass.
// Bypass is compiled in when WB_BYPASS_EN is defined.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic [AWIDTH-1:0] idx_i,
  input  logic [DWIDTH-1:0] regs_i [2**AWIDTH],
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_idx_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  output logic [DWIDTH-1:0] data_o
);
  localparam logic [AWIDTH-1:0] IDX_ZERO = AWIDTH'(REG_ZERO);

`ifdef WB_BYPASS_EN
  always_comb begin
    data_o = regs_i[idx_i];
    if (wr_en_i && (wr_idx_i != IDX_ZERO) && (wr_idx_i == idx_i)) begin
      data_o = wr_data_i;
    end
    if (idx_i == IDX_ZERO) begin
      data_o = '0;
    end
  end
`else
  // Write-side inputs only matter when the bypass is built in.
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_idx_i, wr_data_i};

  always_comb begin
    data_o = regs_i[idx_i];
    if (idx_i == IDX_ZERO) begin
      data_o = '0;
    end
  end
`endif
endmodule

// File: rtl/rv_register_file.sv
// RV32I 32 x 32-bit GPR file: two combinational reads, one synchronous write, x0 tied to zero.
// Optional same-cycle write-through on the read ports with WB_BYPASS_EN.
module rv_register_file
  import rf_pkg::*;
#(
  parameter int                 DWIDTH   = 32,
  parameter int                 AWIDTH   = 5,
  parameter logic [DWIDTH-1:0]  SP_RESET = DWIDTH'(SP_RESET_DEFAULT)
) (
  input logic             clk,
  input logic             rst,
  rv_register_file_if.slave rf
);
  localparam int                NREGS    = 2**AWIDTH;
  localparam logic [AWIDTH-1:0] IDX_ZERO = AWIDTH'(REG_ZERO);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (rf.regwren_i && (rf.rd_i != IDX_ZERO)) begin
      regs_d[rf.rd_i] = rf.datawb_i;
    end
  end

  // Reset takes priority over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_read_port #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_rd1 (
    .idx_i     (rf.rs1_i),
    .regs_i    (regs_q),
    .wr_en_i   (rf.regwren_i),
    .wr_idx_i  (rf.rd_i),
    .wr_data_i (rf.datawb_i),
    .data_o    (rf.rs1data_o)
  );

  rf_read_port #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_rd2 (
    .idx_i     (rf.rs2_i),
    .regs_i    (regs_q),
    .wr_en_i   (rf.regwren_i),
    .wr_idx_i  (rf.rd_i),
    .wr_data_i (rf.datawb_i),
    .data_o    (rf.rs2data_o)
  );
endmodule

// File: tb/tb_rv_register_file.sv
// Self-checking bench for rv_register_file: directed cases then randomized traffic vs. an array model.
module tb_rv_register_file;
  localparam logic [31:0] SP_VAL = 32'h0110_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  logic [31:0] model [32];

  rv_register_file_if #(.DWIDTH(32), .AWIDTH(5)) rf ();

  rv_register_file dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value given the current model and the write presented this cycle.
  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (!rst && rf.regwren_i && rf.rd_i != 5'd0 && rf.rd_i == idx) return rf.datawb_i;
`else
    if (rst && idx == 5'd31 && model[31] === 32'hx) return 32'h0;
`endif
    return model[idx];
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (model[i]) model[i] = 32'h0;
      model[2] = SP_VAL;
    end else if (rf.regwren_i && rf.rd_i != 5'd0) begin
      model[rf.rd_i] = rf.datawb_i;
    end
  endtask

  // Drive one cycle, check both read ports before the edge, then clock it.
  task automatic cycle(input string tag, input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic [31:0] d, input logic we);
    @(negedge clk);
    rst          = r;
    rf.rs1_i     = a1;
    rf.rs2_i     = a2;
    rf.rd_i      = rd;
    rf.datawb_i  = d;
    rf.regwren_i = we;
    #1;
    if (n_checks >= 0 && tag != "") begin
      check({tag, "_rs1"}, rf.rs1data_o, exp_read(a1));
      check({tag, "_rs2"}, rf.rs2data_o, exp_read(a2));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    foreach (model[i]) model[i] = 32'h0;
    model[2] = SP_VAL;
    rst = 1'b1;
    rf.rs1_i = '0; rf.rs2_i = '0; rf.rd_i = '0; rf.datawb_i = '0; rf.regwren_i = 1'b0;

    // 1. reset, with a write presented that must be dropped
    cycle("", 1'b1, 5'd0, 5'd2, 5'd7, 32'h1111_1111, 1'b1);
    @(negedge clk);
    rst = 1'b0; rf.regwren_i = 1'b0; rf.rs1_i = 5'd0; rf.rs2_i = 5'd2;
    #1;
    check("reset_x0", rf.rs1data_o, 32'h0);
    check("reset_sp", rf.rs2data_o, 32'h0110_0000);
    rf.rs1_i = 5'd7;
    #1;
    check("reset_drops_write", rf.rs1data_o, 32'h0);

    // 2. basic writes and overwrite
    cycle("w5",  1'b0, 5'd0, 5'd0, 5'd5,  32'd123, 1'b1);
    cycle("w10", 1'b0, 5'd0, 5'd0, 5'd10, 32'd999, 1'b1);
    @(negedge clk); rf.regwren_i = 1'b0; rf.rs1_i = 5'd10; rf.rs2_i = 5'd5; #1;
    check("rd10", rf.rs1data_o, 32'd999);
    check("rd5",  rf.rs2data_o, 32'd123);
    cycle("ow5", 1'b0, 5'd0, 5'd0, 5'd5, 32'd777, 1'b1);
    @(negedge clk); rf.regwren_i = 1'b0; rf.rs1_i = 5'd5; rf.rs2_i = 5'd10; #1;
    check("rd5_ow", rf.rs1data_o, 32'd777);
    check("rd10_b", rf.rs2data_o, 32'd999);

    // 3. write to x0 discarded
    cycle("w0", 1'b0, 5'd0, 5'd5, 5'd0, 32'd555, 1'b1);
    @(negedge clk); rf.regwren_i = 1'b0; rf.rs1_i = 5'd0; rf.rs2_i = 5'd5; #1;
    check("x0_zero", rf.rs1data_o, 32'h0);
    check("x5_kept", rf.rs2data_o, 32'd777);

    // 4. write enable low
    cycle("nowe", 1'b0, 5'd20, 5'd20, 5'd20, 32'hCAFE_BABE, 1'b0);
    @(negedge clk); rf.rs1_i = 5'd20; #1;
    check("x20_zero", rf.rs1data_o, 32'h0);

    // 5. high indices and same-cycle index change
    cycle("w31", 1'b0, 5'd0, 5'd0, 5'd31, 32'hDEAD_BEEF, 1'b1);
    cycle("w16", 1'b0, 5'd0, 5'd0, 5'd16, 32'h1234_5678, 1'b1);
    @(negedge clk); rf.regwren_i = 1'b0; rf.rs1_i = 5'd31; rf.rs2_i = 5'd16; #1;
    check("rd31", rf.rs1data_o, 32'hDEAD_BEEF);
    check("rd16", rf.rs2data_o, 32'h1234_5678);
    rf.rs1_i = 5'd16; #1;
    check("rs1_follow", rf.rs1data_o, 32'h1234_5678);

    // 6. read-during-write on x15
    @(negedge clk);
    rf.rs1_i = 5'd15; rf.rs2_i = 5'd15; rf.rd_i = 5'd15; rf.datawb_i = 32'd42; rf.regwren_i = 1'b1; #1;
`ifdef WB_BYPASS_EN
    check("rdw_same", rf.rs1data_o, 32'd42);
`else
    check("rdw_same", rf.rs1data_o, 32'd0);
`endif
    check("rdw_port2", rf.rs2data_o, exp_read(5'd15));
    @(posedge clk); model_edge(); #1;
    @(negedge clk); rf.regwren_i = 1'b0; #1;
    check("rdw_after", rf.rs1data_o, 32'd42);

    // Randomized traffic with occasional mid-operation resets
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", ($urandom_range(0, 39) == 0), 5'($urandom), 5'($urandom),
            5'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    end

    // Final sweep of every register through both ports
    for (int i = 0; i < 32; i++) begin
      cycle("sweep", 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fails++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
